edge_list_encoder: RTL and testbench

Serializes a stream of directed graph edges into the puzzle's ASCII adjacency-list format ("src: dst dst ...\n"), one byte per handshake. It is the transmit-side counterpart of `input_decoder` and is used to regenerate input byte streams from edge lists for loopback benches and on-chip stimulus. The output is framed so that feeding it straight into `input_decoder` reproduces the same edges, followed by `decoding_done` on end-of-file.

---
 rtl/edge_list_encoder.sv | 236 +++++++++++++++++++++++
 tb/tb_edge_list_encoder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_list_encoder.sv
// edge_list_encoder
//   Serializes a stream of directed graph edges into an ASCII adjacency list
//   ("src: dst dst ...\n"), one byte per handshake. An empty line ("\n" at the
//   start of a line) marks end-of-file. The output stream can be fed straight
//   back into input_decoder to reproduce the same edges.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   edge_valid/edge_ready   edge handshake; edge_last closes the source's line
//   src_node, dst_node      node IDs, char 0 in the low 5 bits, code 0 = 'a'
//   eof_valid/eof_ready     end-of-file handshake, only accepted with no line open
//   byte_valid/byte_ready   output byte handshake, byte_data is registered
//   encoding_done           one-cycle pulse after the EOF byte is accepted
//   encoding_error          sticky: bad char code or source change mid-line
module edge_list_encoder #(
    parameter int NODE_CHARS    = 3,
    parameter int NODE_BIN_BITS = 5,
    parameter int NODE_WIDTH    = NODE_CHARS * NODE_BIN_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  edge_valid,
    output logic                  edge_ready,
    input  logic                  edge_last,
    input  logic [NODE_WIDTH-1:0] src_node,
    input  logic [NODE_WIDTH-1:0] dst_node,
    input  logic                  eof_valid,
    output logic                  eof_ready,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [7:0]            byte_data,
    output logic                  encoding_done,
    output logic                  encoding_error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_OPEN,
        S_SRC,
        S_COLON,
        S_SPACE,
        S_DST,
        S_LF,
        S_EOF,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(NODE_CHARS - 1);
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_A     = 8'h61;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [NODE_WIDTH-1:0]   src_q, src_d;
    logic [NODE_WIDTH-1:0]   dst_q, dst_d;
    logic                    last_q, last_d;
    logic                    bvalid_q, bvalid_d;
    logic [7:0]              bdata_q, bdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    hs;
    logic                    load_char;
    logic [NODE_BIN_BITS-1:0] code;
    logic [1:0]              idx_inc;

    function automatic logic [NODE_BIN_BITS-1:0] char_of(
        input logic [NODE_WIDTH-1:0] node,
        input logic [1:0]            idx
    );
        case (idx)
            2'd0:    return node[NODE_BIN_BITS-1:0];
            2'd1:    return node[2*NODE_BIN_BITS-1:NODE_BIN_BITS];
            default: return node[3*NODE_BIN_BITS-1:2*NODE_BIN_BITS];
        endcase
    endfunction

    assign edge_ready     = (state_q == S_IDLE) || (state_q == S_OPEN);
    assign eof_ready      = (state_q == S_IDLE);
    assign byte_valid     = bvalid_q;
    assign byte_data      = bdata_q;
    assign encoding_done  = done_q;
    assign encoding_error = err_q;

    assign hs      = bvalid_q && byte_ready;
    assign idx_inc = idx_q + 2'd1;

    // byte_data_q always holds the byte belonging to the current state; a
    // handshake loads the byte of the following state in the same cycle, so
    // bytes stream back-to-back while byte_ready is held.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        src_d     = src_q;
        dst_d     = dst_q;
        last_d    = last_q;
        bvalid_d  = bvalid_q;
        bdata_d   = bdata_q;
        done_d    = 1'b0;
        err_d     = err_q;
        load_char = 1'b0;
        code      = '0;

        unique case (state_q)
            S_IDLE: begin
                // an edge takes priority over a simultaneous EOF request
                if (edge_valid) begin
                    src_d     = src_node;
                    dst_d     = dst_node;
                    last_d    = edge_last;
                    idx_d     = 2'd0;
                    state_d   = S_SRC;
                    bvalid_d  = 1'b1;
                    load_char = 1'b1;
                    code      = char_of(src_node, 2'd0);
                end else if (eof_valid) begin
                    state_d  = S_EOF;
                    bvalid_d = 1'b1;
                    bdata_d  = CH_LF;
                end
            end
            S_OPEN: begin
                // the line keeps its original source; a different source is
                // flagged but not re-emitted
                if (edge_valid) begin
                    if (src_node != src_q) begin
                        err_d = 1'b1;
                    end
                    dst_d    = dst_node;
                    last_d   = edge_last;
                    state_d  = S_SPACE;
                    bvalid_d = 1'b1;
                    bdata_d  = CH_SPACE;
                end
            end
            S_SRC: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COLON;
                        bdata_d = CH_COLON;
                    end else begin
                        idx_d     = idx_inc;
                        load_char = 1'b1;
                        code      = char_of(src_q, idx_inc);
                    end
                end
            end
            S_COLON: begin
                if (hs) begin
                    state_d = S_SPACE;
                    bdata_d = CH_SPACE;
                end
            end
            S_SPACE: begin
                if (hs) begin
                    state_d   = S_DST;
                    idx_d     = 2'd0;
                    load_char = 1'b1;
                    code      = char_of(dst_q, 2'd0);
                end
            end
            S_DST: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        if (last_q) begin
                            state_d = S_LF;
                            bdata_d = CH_LF;
                        end else begin
                            state_d  = S_OPEN;
                            bvalid_d = 1'b0;
                        end
                    end else begin
                        idx_d     = idx_inc;
                        load_char = 1'b1;
                        code      = char_of(dst_q, idx_inc);
                    end
                end
            end
            S_LF: begin
                if (hs) begin
                    state_d  = S_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            S_EOF: begin
                if (hs) begin
                    state_d  = S_DONE;
                    bvalid_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
                bvalid_d = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                bvalid_d = 1'b0;
            end
        endcase

        // codes 26..31 still go out (as 0x7B..0x80) but mark the stream bad
        if (load_char) begin
            bdata_d = CH_A + {3'b000, code};
            if (code > 5'd25) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            last_q   <= 1'b0;
            bvalid_q <= 1'b0;
            bdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            last_q   <= last_d;
            bvalid_q <= bvalid_d;
            bdata_q  <= bdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_edge_list_encoder.sv
module tb_edge_list_encoder;

    localparam logic [14:0] N_YOU = 15'h51D8;
    localparam logic [14:0] N_BBB = 15'h0421;
    localparam logic [14:0] N_CCC = 15'h0842;
    localparam logic [14:0] N_OUT = 15'h4E8E;
    localparam logic [14:0] N_BAD = 15'h035A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        edge_valid = 1'b0;
    logic        edge_last = 1'b0;
    logic        eof_valid = 1'b0;
    logic        byte_ready = 1'b0;
    logic [14:0] src_node = '0;
    logic [14:0] dst_node = '0;
    logic        edge_ready;
    logic        eof_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        encoding_done;
    logic        encoding_error;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  got[$];
    int          done_cnt = 0;
    int          ready_mode = 0;
    bit          tog = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    always #5 clk = ~clk;

    edge_list_encoder #(
        .NODE_CHARS    (3),
        .NODE_BIN_BITS (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .edge_valid     (edge_valid),
        .edge_ready     (edge_ready),
        .edge_last      (edge_last),
        .src_node       (src_node),
        .dst_node       (dst_node),
        .eof_valid      (eof_valid),
        .eof_ready      (eof_ready),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .byte_data      (byte_data),
        .encoding_done  (encoding_done),
        .encoding_error (encoding_error)
    );

    // downstream ready: 0 = always ready, 1 = toggling with random extra stalls
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        if (ready_mode == 0) byte_ready = 1'b1;
        else if (ready_mode == 1) byte_ready = tog && ($urandom_range(0, 3) != 0);
        else byte_ready = 1'b0;
    end

    // byte capture and stall-hold check, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (byte_valid !== 1'b1 || byte_data !== prev_data) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             byte_valid, byte_data, prev_data);
                end
            end
            if (byte_valid === 1'b1 && byte_ready === 1'b1) got.push_back(byte_data);
            if (encoding_done === 1'b1) done_cnt++;
            prev_stall = (byte_valid === 1'b1) && (byte_ready === 1'b0);
            prev_data  = byte_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        edge_valid = 1'b0;
        eof_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        done_cnt = 0;
    endtask

    // called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send_edge(input logic [14:0] s, input logic [14:0] d, input logic l);
        int unsigned c = 0;
        src_node   = s;
        dst_node   = d;
        edge_last  = l;
        edge_valid = 1'b1;
        @(negedge clk);
        while (edge_ready !== 1'b1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (edge_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL edge_accept_timeout: edge_ready=%b, required 1", edge_ready);
        end
        @(posedge clk);
        #1;
        edge_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string name);
        int unsigned c = 0;
        while (got.size() < n && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        tests++;
        if (got.size() < n) begin
            fails++;
            $display("FAIL %s_timeout: got %0d bytes, required %0d", name, got.size(), n);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (edge_ready !== 1'b1 || eof_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: edge_ready=%b eof_ready=%b, required 1 1", edge_ready, eof_ready);
        end
        tests++;
        if (byte_valid !== 1'b0 || byte_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_byte: valid=%b data=%h, required 0 00", byte_valid, byte_data);
        end
        tests++;
        if (encoding_done !== 1'b0 || encoding_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: done=%b error=%b, required 0 0", encoding_done, encoding_error);
        end
        do_reset();
    endtask

    task automatic test_basic_line();
        logic [7:0] exp[13] = '{8'h79, 8'h6F, 8'h75, 8'h3A, 8'h20, 8'h62, 8'h62, 8'h62,
                                8'h20, 8'h63, 8'h63, 8'h63, 8'h0A};
        logic [7:0] g;
        do_reset();
        ready_mode = 0;
        send_edge(N_YOU, N_BBB, 1'b0);
        tests++;
        if (edge_ready !== 1'b0 || byte_valid !== 1'b1 || byte_data !== 8'h79) begin
            fails++;
            $display("FAIL basic_first_byte: edge_ready=%b valid=%b data=%h, required 0 1 79",
                     edge_ready, byte_valid, byte_data);
        end
        send_edge(N_YOU, N_CCC, 1'b1);
        wait_bytes(13, "basic");
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (got.size() != 13) begin
            fails++;
            $display("FAIL basic_count: got %0d bytes, required 13", got.size());
        end
        for (int i = 0; i < 13; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tests++;
            if (g !== exp[i]) begin
                fails++;
                $display("FAIL basic_byte[%0d]: got %h, required %h", i, g, exp[i]);
            end
        end
        tests++;
        if (encoding_error !== 1'b0 || edge_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_end: error=%b edge_ready=%b, required 0 1", encoding_error, edge_ready);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp[13] = '{8'h79, 8'h6F, 8'h75, 8'h3A, 8'h20, 8'h62, 8'h62, 8'h62,
                                8'h20, 8'h63, 8'h63, 8'h63, 8'h0A};
        logic [7:0] g;
        do_reset();
        ready_mode = 1;
        send_edge(N_YOU, N_BBB, 1'b0);
        send_edge(N_YOU, N_CCC, 1'b1);
        wait_bytes(13, "stall");
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (got.size() != 13) begin
            fails++;
            $display("FAIL stall_count: got %0d bytes, required 13", got.size());
        end
        for (int i = 0; i < 13; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tests++;
            if (g !== exp[i]) begin
                fails++;
                $display("FAIL stall_byte[%0d]: got %h, required %h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_eof();
        int unsigned c = 0;
        logic [7:0] g;
        do_reset();
        ready_mode = 0;
        send_edge(N_YOU, N_BBB, 1'b0);
        send_edge(N_YOU, N_CCC, 1'b1);
        wait_bytes(13, "eof_line");
        eof_valid = 1'b1;
        @(negedge clk);
        while (eof_ready !== 1'b1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (eof_ready !== 1'b1) begin
            fails++;
            $display("FAIL eof_accept: eof_ready=%b, required 1", eof_ready);
        end
        @(posedge clk);
        #1;
        eof_valid = 1'b0;
        wait_bytes(14, "eof_byte");
        repeat (4) @(posedge clk);
        #1;
        g = (got.size() > 13) ? got[13] : 8'hxx;
        tests++;
        if (g !== 8'h0A) begin
            fails++;
            $display("FAIL eof_byte: got %h, required 0a", g);
        end
        tests++;
        if (done_cnt != 1 || encoding_done !== 1'b0) begin
            fails++;
            $display("FAIL eof_done_pulse: pulses=%0d done=%b, required 1 0", done_cnt, encoding_done);
        end
        edge_valid = 1'b1;
        src_node   = N_YOU;
        dst_node   = N_BBB;
        edge_last  = 1'b1;
        eof_valid  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (edge_ready !== 1'b0 || eof_ready !== 1'b0 || byte_valid !== 1'b0 || got.size() != 14) begin
            fails++;
            $display("FAIL eof_done_locked: edge_ready=%b eof_ready=%b valid=%b bytes=%0d, required 0 0 0 14",
                     edge_ready, eof_ready, byte_valid, got.size());
        end
        edge_valid = 1'b0;
        eof_valid  = 1'b0;
    endtask

    task automatic test_bad_char();
        logic [7:0] exp[9] = '{8'h79, 8'h6F, 8'h75, 8'h3A, 8'h20, 8'h7B, 8'h7B, 8'h61, 8'h0A};
        logic [7:0] g;
        do_reset();
        ready_mode = 0;
        send_edge(N_YOU, N_BAD, 1'b1);
        wait_bytes(9, "badchar");
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tests++;
            if (g !== exp[i]) begin
                fails++;
                $display("FAIL badchar_byte[%0d]: got %h, required %h", i, g, exp[i]);
            end
        end
        tests++;
        if (encoding_error !== 1'b1) begin
            fails++;
            $display("FAIL badchar_error: got %b, required 1", encoding_error);
        end
        send_edge(N_YOU, N_BBB, 1'b1);
        wait_bytes(18, "badchar_next");
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (encoding_error !== 1'b1) begin
            fails++;
            $display("FAIL badchar_sticky: got %b, required 1", encoding_error);
        end
    endtask

    task automatic test_src_mismatch();
        logic [7:0] exp[13] = '{8'h79, 8'h6F, 8'h75, 8'h3A, 8'h20, 8'h62, 8'h62, 8'h62,
                                8'h20, 8'h63, 8'h63, 8'h63, 8'h0A};
        logic [7:0] g;
        do_reset();
        ready_mode = 0;
        send_edge(N_YOU, N_BBB, 1'b0);
        wait_bytes(8, "mismatch_first");
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (encoding_error !== 1'b0) begin
            fails++;
            $display("FAIL mismatch_pre_error: got %b, required 0", encoding_error);
        end
        send_edge(N_OUT, N_CCC, 1'b1);
        wait_bytes(13, "mismatch");
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tests++;
            if (g !== exp[i]) begin
                fails++;
                $display("FAIL mismatch_byte[%0d]: got %h, required %h", i, g, exp[i]);
            end
        end
        tests++;
        if (encoding_error !== 1'b1) begin
            fails++;
            $display("FAIL mismatch_error: got %b, required 1", encoding_error);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp[9] = '{8'h79, 8'h6F, 8'h75, 8'h3A, 8'h20, 8'h6F, 8'h75, 8'h74, 8'h0A};
        logic [7:0] g;
        do_reset();
        ready_mode = 0;
        send_edge(N_YOU, N_OUT, 1'b1);
        wait_bytes(6, "midreset_pre");
        tests++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h75) begin
            fails++;
            $display("FAIL midreset_dst1: valid=%b data=%h, required 1 75", byte_valid, byte_data);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (byte_valid !== 1'b0 || byte_data !== 8'h00 || edge_ready !== 1'b1 || eof_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_async: valid=%b data=%h edge_ready=%b eof_ready=%b, required 0 00 1 1",
                     byte_valid, byte_data, edge_ready, eof_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        send_edge(N_YOU, N_OUT, 1'b1);
        wait_bytes(9, "midreset_post");
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (got.size() != 9) begin
            fails++;
            $display("FAIL midreset_count: got %0d bytes, required 9", got.size());
        end
        for (int i = 0; i < 9; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            tests++;
            if (g !== exp[i]) begin
                fails++;
                $display("FAIL midreset_byte[%0d]: got %h, required %h", i, g, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_stall();
        test_eof();
        test_bad_char();
        test_src_mismatch();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
